// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: register map, control bits and sequencer states for the interval timer.
package timer_regs_pkg;
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERL    = 3'd2;
    localparam logic [2:0] ADDR_PERH    = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;
    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;
    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_ACK,
        S_WR_STOP, S_SNAP_WR, S_RD_L, S_RD_H, S_RD_DONE
    } state_t;
    function automatic logic [15:0] ctrl_start(input logic cont);
        logic [15:0] w;
        w = '0;
        w[ITO] = 1'b1;
        w[CONT] = cont;
        w[START] = 1'b1;
        return w;
    endfunction
    function automatic logic [15:0] ctrl_stop();
        logic [15:0] w;
        w = '0;
        w[STOP] = 1'b1;
        return w;
    endfunction
endpackage

// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: drives the interval timer's Avalon slave so fabric logic can
// start/stop it, get a tick per timeout and read back the counter snapshot.
module timer_seq_ctrl
    import timer_regs_pkg::*;
#(
    parameter logic [31:0] MIN_PERIOD = 32'd16,
    parameter int          TICK_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_continuous,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    output logic              cmd_ready,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              snap_valid,
    output logic [31:0]       snap_value,
    output logic [2:0]        tm_address,
    output logic              tm_chipselect,
    output logic              tm_write_n,
    output logic [15:0]       tm_writedata,
    input  logic [15:0]       tm_readdata,
    input  logic              tm_irq
);
    state_t            state_q, state_d;
    logic [31:0]       period_q, period_d, snap_q, snap_d;
    logic              cont_q, cont_d, busy_q, busy_d;
    logic [TICK_W-1:0] tick_count_q, tick_count_d;
    logic [31:0]       period_clamped;

    assign period_clamped = (cfg_period < MIN_PERIOD) ? MIN_PERIOD : cfg_period;
    assign cmd_ready  = (state_q == S_IDLE) || (state_q == S_RUN && !tm_irq);
    assign busy       = busy_q;
    assign tick       = state_q == S_ACK;
    assign tick_count = tick_count_q;
    assign snap_valid = state_q == S_RD_DONE;
    // The high half is forwarded straight from the bus so snap_value is complete during the pulse.
    assign snap_value = snap_valid ? {tm_readdata, snap_q[15:0]} : snap_q;
    assign tm_write_n = ~tm_chipselect;

    always_comb begin
        state_d = state_q;
        period_d = period_q;
        cont_d = cont_q;
        busy_d = busy_q;
        snap_d = snap_q;
        tick_count_d = tick_count_q;
        tm_address = ADDR_STATUS;
        tm_chipselect = 1'b0;
        tm_writedata = '0;
        case (state_q)
            S_IDLE: begin
                if (!cmd_stop && cmd_start) begin
                    period_d = period_clamped;
                    cont_d = cfg_continuous;
                    state_d = S_WR_PL;
                end else if (!cmd_stop && cmd_snap) state_d = S_SNAP_WR;
            end
            S_WR_PL: begin
                tm_chipselect = 1'b1;
                tm_address = ADDR_PERL;
                tm_writedata = period_q[15:0];
                state_d = S_WR_PH;
            end
            S_WR_PH: begin
                tm_chipselect = 1'b1;
                tm_address = ADDR_PERH;
                tm_writedata = period_q[31:16];
                state_d = S_WR_CTRL;
            end
            S_WR_CTRL: begin
                tm_chipselect = 1'b1;
                tm_address = ADDR_CONTROL;
                tm_writedata = ctrl_start(cont_q);
                busy_d = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (tm_irq) state_d = S_ACK;
                else if (cmd_stop) state_d = S_WR_STOP;
                else if (cmd_start) begin
                    period_d = period_clamped;
                    cont_d = cfg_continuous;
                    state_d = S_WR_PL;
                end else if (cmd_snap) state_d = S_SNAP_WR;
            end
            S_ACK: begin
                tm_chipselect = 1'b1;
                tick_count_d = tick_count_q + TICK_W'(1);
                busy_d = cont_q;
                state_d = cont_q ? S_RUN : S_IDLE;
            end
            S_WR_STOP: begin
                tm_chipselect = 1'b1;
                tm_address = ADDR_CONTROL;
                tm_writedata = ctrl_stop();
                busy_d = 1'b0;
                state_d = S_IDLE;
            end
            S_SNAP_WR: begin
                tm_chipselect = 1'b1;
                tm_address = ADDR_SNAPL;
                state_d = S_RD_L;
            end
            S_RD_L: begin
                tm_address = ADDR_SNAPL;
                state_d = S_RD_H;
            end
            S_RD_H: begin
                tm_address = ADDR_SNAPH;
                snap_d[15:0] = tm_readdata;
                state_d = S_RD_DONE;
            end
            S_RD_DONE: begin
                snap_d[31:16] = tm_readdata;
                state_d = busy_q ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            period_q <= '0;
            cont_q <= 1'b0;
            busy_q <= 1'b0;
            snap_q <= '0;
            tick_count_q <= '0;
        end else begin
            state_q <= state_d;
            period_q <= period_d;
            cont_q <= cont_d;
            busy_q <= busy_d;
            snap_q <= snap_d;
            tick_count_q <= tick_count_d;
        end
    end
endmodule

// File: tb/tb_timer_seq_ctrl.sv
// tb_timer_seq_ctrl: directed bench with a small timer model; bus writes and
// snapshots are checked against scoreboard queues as the DUT produces them.
module tb_timer_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cfg_period = '0;
    logic        cfg_continuous = 1'b0;
    logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_snap = 1'b0;
    logic        cmd_ready, busy, tick, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic [2:0]  tm_address;
    logic        tm_chipselect, tm_write_n;
    logic [15:0] tm_writedata;
    logic [15:0] tm_readdata = '0;
    logic        tm_irq = 1'b0;
    logic        fire = 1'b0;
    logic [31:0] count_val = '0;
    logic [31:0] snap_reg = '0;
    int          n_cmp = 0, n_bad = 0;
    logic [18:0] exp_wr[$];
    logic [31:0] exp_snap[$];

    timer_seq_ctrl dut (
        .clk(clk), .reset(reset), .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap), .cmd_ready(cmd_ready),
        .busy(busy), .tick(tick), .tick_count(tick_count), .snap_valid(snap_valid),
        .snap_value(snap_value), .tm_address(tm_address), .tm_chipselect(tm_chipselect),
        .tm_write_n(tm_write_n), .tm_writedata(tm_writedata), .tm_readdata(tm_readdata),
        .tm_irq(tm_irq)
    );

    always #5 clk = ~clk;

    // Timer model: irq held until a status write, snapshot latched by a write to snap_l.
    always @(posedge clk) begin
        if (fire) tm_irq <= 1'b1;
        else if (tm_chipselect && !tm_write_n && tm_address == 3'd0) tm_irq <= 1'b0;
        if (tm_chipselect && !tm_write_n && tm_address == 3'd4) snap_reg <= count_val;
        tm_readdata <= (tm_address == 3'd4) ? snap_reg[15:0] :
                       (tm_address == 3'd5) ? snap_reg[31:16] : 16'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && tm_chipselect && !tm_write_n) begin
            if (exp_wr.size() == 0) chk("unexpected_write", {13'h0, tm_address, tm_writedata}, 32'hFFFF_FFFF);
            else chk("bus_write", {13'h0, tm_address, tm_writedata}, {13'h0, exp_wr.pop_front()});
        end
        if (!reset && snap_valid) begin
            if (exp_snap.size() == 0) chk("unexpected_snap", snap_value, 32'hFFFF_FFFF);
            else chk("snap_value", snap_value, exp_snap.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic timeout_irq(input int idx);
        exp_wr.push_back({3'd0, 16'h0000});
        fire = 1'b1;
        cyc(1);
        fire = 1'b0;
        chk($sformatf("ready_low_irq%0d", idx), cmd_ready, 1'b0);
        cyc(1);
        chk($sformatf("tick_pulse%0d", idx), tick, 1'b1);
        cyc(1);
        chk($sformatf("tick_done%0d", idx), tick, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_cs", tm_chipselect, 1'b0);
        chk("rst_wn", tm_write_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        cyc(1);
        chk("rst_tick_count", tick_count, 16'h0);
        chk("rst_snap", snap_value, 32'h0);
        // Periodic start
        exp_wr.push_back({3'd2, 16'h86A0});
        exp_wr.push_back({3'd3, 16'h0001});
        exp_wr.push_back({3'd1, 16'h0007});
        cfg_period = 32'h0001_86A0;
        cfg_continuous = 1'b1;
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        chk("busy_during_prog", busy, 1'b0);
        cyc(3);
        chk("busy_running", busy, 1'b1);
        chk("prog_writes_done", exp_wr.size(), 0);
        // Three periodic timeouts
        for (int i = 0; i < 3; i++) begin
            cyc(2);
            timeout_irq(i);
            chk($sformatf("tick_count%0d", i), tick_count, 16'(i + 1));
        end
        chk("busy_after_ticks", busy, 1'b1);
        // Snapshot while running
        count_val = 32'h0000_1234;
        exp_wr.push_back({3'd4, 16'h0000});
        exp_snap.push_back(32'h0000_1234);
        cmd_snap = 1'b1;
        cyc(1);
        cmd_snap = 1'b0;
        chk("addr_snap_wr", tm_address, 3'd4);
        cyc(1);
        chk("addr_rd_l", tm_address, 3'd4);
        cyc(1);
        chk("addr_rd_h", tm_address, 3'd5);
        cyc(1);
        chk("snap_valid_pulse", snap_valid, 1'b1);
        cyc(1);
        chk("snap_valid_single", snap_valid, 1'b0);
        chk("snap_held", snap_value, 32'h0000_1234);
        chk("run_after_snap", cmd_ready, 1'b1);
        // irq with stop+start in the same cycle: commands ignored, irq acked
        exp_wr.push_back({3'd0, 16'h0000});
        fire = 1'b1;
        cyc(1);
        fire = 1'b0;
        cmd_stop = 1'b1;
        cmd_start = 1'b1;
        cfg_period = 32'h0000_0100;
        #1;
        chk("ready_low_cmds", cmd_ready, 1'b0);
        cyc(1);
        cmd_stop = 1'b0;
        cmd_start = 1'b0;
        chk("ack_first", tick, 1'b1);
        cyc(1);
        chk("busy_cmds_ignored", busy, 1'b1);
        chk("tick_count4", tick_count, 16'd4);
        // Later stop
        exp_wr.push_back({3'd1, 16'h0008});
        cmd_stop = 1'b1;
        cyc(1);
        cmd_stop = 1'b0;
        cyc(1);
        chk("busy_stopped", busy, 1'b0);
        chk("idle_ready", cmd_ready, 1'b1);
        // One-shot with clamped period
        exp_wr.push_back({3'd2, 16'h0010});
        exp_wr.push_back({3'd3, 16'h0000});
        exp_wr.push_back({3'd1, 16'h0005});
        cfg_period = 32'd5;
        cfg_continuous = 1'b0;
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cyc(3);
        chk("oneshot_busy", busy, 1'b1);
        cyc(2);
        timeout_irq(9);
        chk("oneshot_idle_busy", busy, 1'b0);
        chk("oneshot_idle_ready", cmd_ready, 1'b1);
        chk("tick_count5", tick_count, 16'd5);
        // Snapshot from idle, full 32-bit value
        count_val = 32'hBEEF_1234;
        exp_wr.push_back({3'd4, 16'h0000});
        exp_snap.push_back(32'hBEEF_1234);
        cmd_snap = 1'b1;
        cyc(1);
        cmd_snap = 1'b0;
        cyc(4);
        chk("idle_snap_held", snap_value, 32'hBEEF_1234);
        chk("idle_snap_busy", busy, 1'b0);
        chk("idle_snap_ready", cmd_ready, 1'b1);
        // Reset during WR_PH
        exp_wr.push_back({3'd2, 16'h0040});
        exp_wr.push_back({3'd3, 16'h0000});
        cfg_period = 32'h40;
        cfg_continuous = 1'b1;
        cmd_start = 1'b1;
        cyc(1);
        cmd_start = 1'b0;
        cyc(1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_cs", tm_chipselect, 1'b0);
        chk("rst_mid_wn", tm_write_n, 1'b1);
        chk("rst_mid_ready", cmd_ready, 1'b1);
        chk("rst_mid_tick_count", tick_count, 16'h0);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        chk("no_bus_after_rst", tm_chipselect, 1'b0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("snap_queue_empty", exp_snap.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
